// File: rtl/as6500_pkg.sv
// Shared types and constants for the AS6500 SPI command sequencer.
package as6500_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, SEND, WAIT_RX, HOLD, GAP} state_t;

  localparam logic [7:0] OPC_RESET  = 8'h30;
  localparam logic [7:0] OPC_INIT   = 8'h18;
  localparam logic [7:0] OPC_WR_CFG = 8'h80;
  localparam logic [7:0] OPC_RD_CFG = 8'h40;
  localparam logic [7:0] OPC_RD_RES = 8'h60;

  localparam logic [4:0] MAX_LEN = 5'd16;

  function automatic logic [4:0] clamp_len(input logic [4:0] len);
    return (len > MAX_LEN) ? MAX_LEN : len;
  endfunction

endpackage

// File: rtl/as6500_spi_seq_spi_master.sv
// SPI byte engine: one TX_DV starts an 8-bit full-duplex transfer, RX_DV
// pulses when the last SCLK edge has been produced.
module SPI_Master #(
  parameter int SPI_MODE          = 0,
  parameter int CLKS_PER_HALF_BIT = 2
) (
  input  logic       i_Rst_L,
  input  logic       i_Clk,
  input  logic [7:0] i_TX_Byte,
  input  logic       i_TX_DV,
  output logic       o_TX_Ready,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_SPI_Clk,
  input  logic       i_SPI_MISO,
  output logic       o_SPI_MOSI
);

  localparam logic CPOL = (SPI_MODE == 2) || (SPI_MODE == 3);
  localparam logic CPHA = (SPI_MODE == 1) || (SPI_MODE == 3);
  localparam int   HW   = $clog2(CLKS_PER_HALF_BIT) + 1;

  logic [HW-1:0] half_cnt;
  logic [4:0]    edges;
  logic [7:0]    tx_sr;
  logic [7:0]    rx_sr;
  logic          leading;

  // Edges count down from 16, so even counts are leading edges.
  assign leading = ~edges[0];

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_SPI_Clk  <= CPOL;
      o_SPI_MOSI <= 1'b0;
      o_TX_Ready <= 1'b0;
      o_RX_DV    <= 1'b0;
      o_RX_Byte  <= 8'h00;
      edges      <= 5'd0;
      half_cnt   <= '0;
      tx_sr      <= 8'h00;
      rx_sr      <= 8'h00;
    end else begin
      o_RX_DV <= 1'b0;
      if (i_TX_DV && edges == 5'd0) begin
        edges      <= 5'd16;
        half_cnt   <= '0;
        o_TX_Ready <= 1'b0;
        if (!CPHA) begin
          o_SPI_MOSI <= i_TX_Byte[7];
          tx_sr      <= {i_TX_Byte[6:0], 1'b0};
        end else begin
          tx_sr <= i_TX_Byte;
        end
      end else if (edges != 5'd0) begin
        if (half_cnt == HW'(CLKS_PER_HALF_BIT - 1)) begin
          half_cnt  <= '0;
          o_SPI_Clk <= ~o_SPI_Clk;
          edges     <= edges - 5'd1;
          if (leading == CPHA) begin
            o_SPI_MOSI <= tx_sr[7];
            tx_sr      <= {tx_sr[6:0], 1'b0};
          end else begin
            rx_sr <= {rx_sr[6:0], i_SPI_MISO};
          end
          if (edges == 5'd1) begin
            o_RX_DV    <= 1'b1;
            o_TX_Ready <= 1'b1;
            o_RX_Byte  <= (leading == CPHA) ? rx_sr : {rx_sr[6:0], i_SPI_MISO};
          end
        end else begin
          half_cnt <= half_cnt + HW'(1);
        end
      end else begin
        o_TX_Ready <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/as6500_spi_seq.sv
// Command sequencer for the AS6500: frames opcode plus payload under CS_n
// with setup, hold and idle-gap timing; o_State exposes the FSM state.
module as6500_spi_seq
  import as6500_pkg::*;
#(
  parameter int SPI_MODE          = 1,
  parameter int CLKS_PER_HALF_BIT = 2,
  parameter int CS_SETUP_CLKS     = 4,
  parameter int CS_HOLD_CLKS      = 4,
  parameter int CS_IDLE_CLKS      = 8
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Cmd_Valid,
  output logic       o_Cmd_Ready,
  input  logic [7:0] i_Cmd_Opcode,
  input  logic [4:0] i_Cmd_Len,
  input  logic       i_Cmd_Wr,
  input  logic       i_Wr_Valid,
  output logic       o_Wr_Ready,
  input  logic [7:0] i_Wr_Byte,
  output logic       o_Rd_Valid,
  output logic [7:0] o_Rd_Byte,
  output logic       o_Busy,
  output logic       o_SPI_Clk,
  output logic       o_SPI_MOSI,
  input  logic       i_SPI_MISO,
  output logic       o_SPI_CS_n,
  output logic [2:0] o_State
);

  localparam int SW = $clog2(CS_SETUP_CLKS) + 1;
  localparam int HW = $clog2(CS_HOLD_CLKS) + 1;
  localparam int GW = $clog2(CS_IDLE_CLKS) + 1;

  state_t        state;
  logic [SW-1:0] setup_cnt;
  logic [HW-1:0] hold_cnt;
  logic [GW-1:0] gap_cnt;
  logic [4:0]    bytes_left;
  logic [7:0]    opcode;
  logic          is_wr;
  logic          opc_phase;
  logic          cs_n;
  logic          tx_dv;
  logic [7:0]    tx_byte;
  logic          tx_ready;
  logic          rx_dv;
  logic [7:0]    rx_byte;
  logic          rd_valid;
  logic [7:0]    rd_byte;
  logic          accept;

  // Handshakes: a command transfers on a cycle where i_Cmd_Valid and
  // o_Cmd_Ready are both high; a write byte transfers on a cycle where
  // i_Wr_Valid and o_Wr_Ready are both high. o_Rd_Valid has no backpressure.
  assign o_Cmd_Ready = (state == IDLE) && tx_ready;
  assign accept      = i_Cmd_Valid && o_Cmd_Ready;
  assign o_Wr_Ready  = (state == SEND) && !opc_phase && is_wr && i_Wr_Valid;
  assign o_Busy      = (state != IDLE);
  assign o_SPI_CS_n  = cs_n;
  assign o_Rd_Valid  = rd_valid;
  assign o_Rd_Byte   = rd_byte;
  assign o_State     = state;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state      <= IDLE;
      setup_cnt  <= '0;
      hold_cnt   <= '0;
      gap_cnt    <= '0;
      bytes_left <= 5'd0;
      opcode     <= 8'h00;
      is_wr      <= 1'b0;
      opc_phase  <= 1'b0;
      cs_n       <= 1'b1;
      tx_dv      <= 1'b0;
      tx_byte    <= 8'h00;
      rd_valid   <= 1'b0;
      rd_byte    <= 8'h00;
    end else begin
      tx_dv    <= 1'b0;
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            opcode     <= i_Cmd_Opcode;
            bytes_left <= clamp_len(i_Cmd_Len);
            is_wr      <= i_Cmd_Wr;
            opc_phase  <= 1'b1;
            cs_n       <= 1'b0;
            setup_cnt  <= SW'(CS_SETUP_CLKS);
            state      <= SETUP;
          end
        end
        SETUP: begin
          if (setup_cnt > SW'(1)) begin
            setup_cnt <= setup_cnt - SW'(1);
          end else begin
            setup_cnt <= '0;
            state     <= SEND;
          end
        end
        SEND: begin
          if (opc_phase) begin
            tx_byte <= opcode;
            tx_dv   <= 1'b1;
            state   <= WAIT_RX;
          end else if (!is_wr || i_Wr_Valid) begin
            // A stalled write stream parks here with SCLK idle and CS_n low.
            tx_byte    <= is_wr ? i_Wr_Byte : 8'h00;
            tx_dv      <= 1'b1;
            bytes_left <= bytes_left - 5'd1;
            state      <= WAIT_RX;
          end
        end
        WAIT_RX: begin
          if (rx_dv) begin
            if (!opc_phase && !is_wr) begin
              rd_valid <= 1'b1;
              rd_byte  <= rx_byte;
            end
            opc_phase <= 1'b0;
            if (bytes_left != 5'd0) begin
              state <= SEND;
            end else begin
              hold_cnt <= HW'(CS_HOLD_CLKS);
              state    <= HOLD;
            end
          end
        end
        HOLD: begin
          if (hold_cnt > HW'(1)) begin
            hold_cnt <= hold_cnt - HW'(1);
          end else begin
            hold_cnt <= '0;
            cs_n     <= 1'b1;
            gap_cnt  <= GW'(CS_IDLE_CLKS);
            state    <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt > GW'(1)) begin
            gap_cnt <= gap_cnt - GW'(1);
          end else begin
            gap_cnt <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  SPI_Master #(
    .SPI_MODE         (SPI_MODE),
    .CLKS_PER_HALF_BIT(CLKS_PER_HALF_BIT)
  ) u_spi (
    .i_Rst_L   (~i_Rst),
    .i_Clk     (i_Clk),
    .i_TX_Byte (tx_byte),
    .i_TX_DV   (tx_dv),
    .o_TX_Ready(tx_ready),
    .o_RX_DV   (rx_dv),
    .o_RX_Byte (rx_byte),
    .o_SPI_Clk (o_SPI_Clk),
    .i_SPI_MISO(i_SPI_MISO),
    .o_SPI_MOSI(o_SPI_MOSI)
  );

endmodule
